// File: rtl/mips150_uart_mmio.sv
// Memory-mapped UART for the MIPS150 I/O space: TX/RX FIFOs, serial engines,
// STATUS/RXDATA/TXDATA/CLEAR registers, sticky error flags and level interrupts.
module mips150_uart_mmio #(
   parameter int unsigned CLOCK_FREQ = 50000000,
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int unsigned TX_DEPTH   = 8,
   parameter int unsigned RX_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        FPGA_SERIAL_RX,
   output logic        FPGA_SERIAL_TX,
   input  logic        io_en,
   input  logic        io_we,
   input  logic [3:0]  io_addr,
   input  logic [7:0]  io_wdata,
   output logic [31:0] io_rdata,
   output logic        rx_irq,
   output logic        tx_irq
);

   localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int unsigned TX_AW        = $clog2(TX_DEPTH);
   localparam int unsigned RX_AW        = $clog2(RX_DEPTH);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_RXDATA = 2'd1;
   localparam logic [1:0] REG_TXDATA = 2'd2;
   localparam logic [1:0] REG_CLEAR  = 2'd3;

   logic       rd, wr;
   logic [1:0] reg_sel;
   logic       unused_addr_bits;

   assign rd               = io_en & ~io_we;
   assign wr               = io_en & io_we;
   assign reg_sel          = io_addr[3:2];
   assign unused_addr_bits = ^io_addr[1:0];

   // TX FIFO
   logic [7:0]     tx_mem [TX_DEPTH];
   logic [TX_AW:0] tx_wptr_q, tx_rptr_q, tx_count;
   logic           tx_empty, tx_full, tx_push, tx_pop;

   // TX engine
   logic [1:0]       tx_state_q;
   logic [CNT_W-1:0] tx_cnt_q;
   logic [2:0]       tx_bit_q;
   logic [7:0]       tx_shift_q;

   assign tx_count = tx_wptr_q - tx_rptr_q;
   assign tx_empty = (tx_wptr_q == tx_rptr_q);
   assign tx_full  = (tx_count == (TX_AW + 1)'(TX_DEPTH));
   assign tx_push  = wr && (reg_sel == REG_TXDATA) && !tx_full;
   assign tx_pop   = (tx_state_q == ST_IDLE) && !tx_empty;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wptr_q[TX_AW-1:0]] <= io_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
      end else begin
         if (tx_push) tx_wptr_q <= tx_wptr_q + (TX_AW + 1)'(1);
         if (tx_pop)  tx_rptr_q <= tx_rptr_q + (TX_AW + 1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= ST_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '1;
      end else begin
         case (tx_state_q)
            ST_IDLE: begin
               tx_cnt_q <= '0;
               if (tx_pop) begin
                  tx_shift_q <= tx_mem[tx_rptr_q[TX_AW-1:0]];
                  tx_state_q <= ST_START;
               end
            end
            ST_START: begin
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q   <= '0;
                  tx_bit_q   <= '0;
                  tx_state_q <= ST_DATA;
               end else tx_cnt_q <= tx_cnt_q + CNT_W'(1);
            end
            ST_DATA: begin
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q   <= '0;
                  tx_shift_q <= {1'b1, tx_shift_q[7:1]};
                  if (tx_bit_q == 3'd7) tx_state_q <= ST_STOP;
                  else tx_bit_q <= tx_bit_q + 3'd1;
               end else tx_cnt_q <= tx_cnt_q + CNT_W'(1);
            end
            ST_STOP: begin
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q   <= '0;
                  tx_state_q <= ST_IDLE;
               end else tx_cnt_q <= tx_cnt_q + CNT_W'(1);
            end
            default: tx_state_q <= ST_IDLE;
         endcase
      end
   end

   assign FPGA_SERIAL_TX = (tx_state_q == ST_START) ? 1'b0 :
                           (tx_state_q == ST_DATA)  ? tx_shift_q[0] : 1'b1;

   // RX synchroniser and engine
   logic             rx_meta_q, rx_sync_q;
   logic [1:0]       rx_state_q;
   logic [CNT_W-1:0] rx_cnt_q;
   logic [2:0]       rx_bit_q;
   logic [7:0]       rx_shift_q;
   logic             rx_stop_done, rx_frame_ok, rx_frame_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= FPGA_SERIAL_RX;
         rx_sync_q <= rx_meta_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q <= ST_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         case (rx_state_q)
            ST_IDLE: begin
               rx_cnt_q <= '0;
               if (!rx_sync_q) rx_state_q <= ST_START;
            end
            ST_START: begin
               // Half-bit check rejects glitches and aligns later samples to mid-bit.
               if (rx_cnt_q == HALF_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_bit_q   <= '0;
                  rx_state_q <= rx_sync_q ? ST_IDLE : ST_DATA;
               end else rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            end
            ST_DATA: begin
               if (rx_cnt_q == BIT_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_state_q <= ST_STOP;
                  else rx_bit_q <= rx_bit_q + 3'd1;
               end else rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            end
            ST_STOP: begin
               if (rx_cnt_q == BIT_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= ST_IDLE;
               end else rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            end
            default: rx_state_q <= ST_IDLE;
         endcase
      end
   end

   assign rx_stop_done = (rx_state_q == ST_STOP) && (rx_cnt_q == BIT_LAST);
   assign rx_frame_ok  = rx_stop_done && rx_sync_q;
   assign rx_frame_bad = rx_stop_done && !rx_sync_q;

   // RX FIFO
   logic [7:0]     rx_mem [RX_DEPTH];
   logic [RX_AW:0] rx_wptr_q, rx_rptr_q, rx_count;
   logic           rx_empty, rx_full, rx_push, rx_pop, rx_drop;
   logic [3:0]     rx_count_sat;

   assign rx_count     = rx_wptr_q - rx_rptr_q;
   assign rx_empty     = (rx_wptr_q == rx_rptr_q);
   assign rx_full      = (rx_count == (RX_AW + 1)'(RX_DEPTH));
   assign rx_pop       = rd && (reg_sel == REG_RXDATA) && !rx_empty;
   // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
   assign rx_push      = rx_frame_ok && (!rx_full || rx_pop);
   assign rx_drop      = rx_frame_ok && rx_full && !rx_pop;
   assign rx_count_sat = (32'(rx_count) > 32'd15) ? 4'd15 : 4'(rx_count);

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wptr_q[RX_AW-1:0]] <= rx_shift_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
      end else begin
         if (rx_push) rx_wptr_q <= rx_wptr_q + (RX_AW + 1)'(1);
         if (rx_pop)  rx_rptr_q <= rx_rptr_q + (RX_AW + 1)'(1);
      end
   end

   // Sticky flags: a new error wins over a same-cycle CLEAR.
   logic overrun_q, frame_err_q, clr;

   assign clr = wr && (reg_sel == REG_CLEAR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         overrun_q   <= rx_drop | (overrun_q & ~(clr & io_wdata[2]));
         frame_err_q <= rx_frame_bad | (frame_err_q & ~(clr & io_wdata[3]));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io_rdata <= '0;
      end else if (rd) begin
         case (reg_sel)
            REG_STATUS: io_rdata <= {20'd0, rx_count_sat, 4'd0,
                                     frame_err_q, overrun_q, ~tx_full, ~rx_empty};
            REG_RXDATA: io_rdata <= rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rptr_q[RX_AW-1:0]]};
            default:    io_rdata <= 32'd0;
         endcase
      end
   end

   assign rx_irq = !rx_empty;
   assign tx_irq = tx_empty && (tx_state_q == ST_IDLE);

endmodule

// File: tb/tb_mips150_uart_mmio.sv
// Directed bench for mips150_uart_mmio at 10 clocks per bit.
module tb_mips150_uart_mmio;

   logic        clk = 1'b0;
   logic        rst, rx_line, tx_line, io_en, io_we, rx_irq, tx_irq;
   logic [3:0]  io_addr;
   logic [7:0]  io_wdata;
   logic [31:0] io_rdata;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   mips150_uart_mmio #(
      .CLOCK_FREQ(1000),
      .BAUD_RATE (100),
      .TX_DEPTH  (8),
      .RX_DEPTH  (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .FPGA_SERIAL_RX(rx_line),
      .FPGA_SERIAL_TX(tx_line),
      .io_en         (io_en),
      .io_we         (io_we),
      .io_addr       (io_addr),
      .io_wdata      (io_wdata),
      .io_rdata      (io_rdata),
      .rx_irq        (rx_irq),
      .tx_irq        (tx_irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic io_write(input logic [3:0] addr, input logic [7:0] data);
      io_en = 1'b1; io_we = 1'b1; io_addr = addr; io_wdata = data;
      cyc(1);
      io_en = 1'b0; io_we = 1'b0;
   endtask

   task automatic io_read(input logic [3:0] addr, output logic [31:0] data);
      io_en = 1'b1; io_we = 1'b0; io_addr = addr;
      cyc(1);
      io_en = 1'b0;
      data = io_rdata;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      rx_line = 1'b0;
      cyc(10);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         cyc(10);
      end
      rx_line = stop_bit;
      cyc(10);
      rx_line = 1'b1;
   endtask

   // Waits for a start edge, then samples each bit at mid-bit.
   task automatic tx_frame(input string tag, input logic [7:0] exp);
      int n;
      logic [7:0] b;
      logic start_bit;
      n = 0;
      while (tx_line !== 1'b0 && n < 400) begin
         cyc(1);
         n++;
      end
      check({tag, "_start_seen"}, 32'(n < 400), 32'd1);
      cyc(4);
      start_bit = tx_line;
      for (int i = 0; i < 8; i++) begin
         cyc(10);
         b[i] = tx_line;
      end
      cyc(10);
      check({tag, "_start_bit"}, {31'd0, start_bit}, 32'd0);
      check({tag, "_data"}, {24'd0, b}, {24'd0, exp});
      check({tag, "_stop_bit"}, {31'd0, tx_line}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, burst_status;
      logic [7:0]  b;
      int          n, lows;

      rst = 1'b1; rx_line = 1'b1; io_en = 1'b0; io_we = 1'b0;
      io_addr = '0; io_wdata = '0;
      cyc(3);
      check("reset_tx_line", {31'd0, tx_line}, 32'd1);
      check("reset_rdata", io_rdata, 32'd0);
      check("reset_rx_irq", {31'd0, rx_irq}, 32'd0);
      check("reset_tx_irq", {31'd0, tx_irq}, 32'd1);
      rst = 1'b0;
      cyc(2);

      // Single frame 0xA5 with exact start-bit length
      io_write(4'h8, 8'hA5);
      check("a5_tx_irq_busy", {31'd0, tx_irq}, 32'd0);
      n = 0;
      while (tx_line !== 1'b0 && n < 50) begin
         cyc(1);
         n++;
      end
      check("a5_start_seen", 32'(n < 50), 32'd1);
      lows = 0;
      while (tx_line === 1'b0 && lows < 50) begin
         lows++;
         cyc(1);
      end
      check("a5_start_len", 32'(lows), 32'd10);
      cyc(4);
      for (int i = 0; i < 8; i++) begin
         b[i] = tx_line;
         cyc(10);
      end
      check("a5_data", {24'd0, b}, 32'h0000_00A5);
      check("a5_stop", {31'd0, tx_line}, 32'd1);
      cyc(10);
      check("a5_tx_irq_idle", {31'd0, tx_irq}, 32'd1);

      // Nine back-to-back writes fit (one already popped); the tenth is dropped
      fork
         begin
            for (int i = 0; i < 9; i++) io_write(4'h8, 8'(8'h11 * (i + 1)));
            io_read(4'h0, burst_status);
            io_write(4'h8, 8'hEE);
         end
         begin
            for (int k = 0; k < 9; k++) tx_frame("burst", 8'(8'h11 * (k + 1)));
         end
      join
      check("burst_full_status", burst_status, 32'h0000_0000);
      lows = 0;
      for (int i = 0; i < 150; i++) begin
         if (tx_line === 1'b0) lows++;
         cyc(1);
      end
      check("burst_no_extra_frame", 32'(lows), 32'd0);
      check("burst_tx_irq", {31'd0, tx_irq}, 32'd1);

      // Receive 0x3C
      check("rx_irq_before", {31'd0, rx_irq}, 32'd0);
      send_rx(8'h3C, 1'b1);
      check("rx_irq_after", {31'd0, rx_irq}, 32'd1);
      io_read(4'h0, rd);
      check("rx_status_one", rd, 32'h0000_0103);
      io_read(4'h4, rd);
      check("rx_data_3c", rd, 32'h0000_003C);
      check("rx_irq_popped", {31'd0, rx_irq}, 32'd0);
      io_read(4'h0, rd);
      check("rx_status_empty", rd, 32'h0000_0002);

      // 4-cycle glitch
      rx_line = 1'b0;
      cyc(4);
      rx_line = 1'b1;
      cyc(30);
      io_read(4'h0, rd);
      check("glitch_status", rd, 32'h0000_0002);
      check("glitch_rx_irq", {31'd0, rx_irq}, 32'd0);

      // Framing error, then CLEAR bit3
      send_rx(8'h55, 1'b0);
      cyc(20);
      io_read(4'h0, rd);
      check("frame_err_status", rd, 32'h0000_000A);
      io_write(4'hC, 8'h08);
      io_read(4'h0, rd);
      check("frame_err_cleared", rd, 32'h0000_0002);

      // Overrun: nine frames into an eight-deep FIFO
      for (int i = 0; i < 9; i++) begin
         send_rx(8'(8'h41 + i), 1'b1);
         cyc(2);
      end
      io_read(4'h0, rd);
      check("overrun_status", rd, 32'h0000_0807);
      for (int i = 0; i < 8; i++) begin
         io_read(4'h4, rd);
         check("overrun_data", rd, 32'(8'h41 + i));
      end
      io_read(4'h0, rd);
      check("overrun_drained", rd, 32'h0000_0006);
      io_read(4'h4, rd);
      check("empty_rxdata", rd, 32'h0000_0000);
      io_read(4'h0, rd);
      check("empty_count", rd, 32'h0000_0006);

      // Reset in the middle of a TX frame (also clears the sticky overrun)
      io_write(4'h8, 8'h00);
      cyc(25);
      check("midtx_line_low", {31'd0, tx_line}, 32'd0);
      rst = 1'b1;
      #1;
      check("midtx_rst_line", {31'd0, tx_line}, 32'd1);
      check("midtx_rst_tx_irq", {31'd0, tx_irq}, 32'd1);
      check("midtx_rst_rx_irq", {31'd0, rx_irq}, 32'd0);
      check("midtx_rst_rdata", io_rdata, 32'd0);
      cyc(2);
      rst = 1'b0;
      cyc(2);
      io_read(4'h0, rd);
      check("post_reset_status", rd, 32'h0000_0002);
      lows = 0;
      for (int i = 0; i < 120; i++) begin
         if (tx_line === 1'b0) lows++;
         cyc(1);
      end
      check("post_reset_tx_quiet", 32'(lows), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
